// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the fetch stage: FSM state codes, word/field
// widths, and the redirect request bundle passed to the next-PC mux.
package fetch_unit_pkg;

    localparam int WORD_W = 32;
    localparam int JIDX_W = 26;
    localparam int BOFF_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_HALTED = 2'd2;

    typedef struct packed {
        logic                     jr;
        logic [WORD_W-1:0]        jr_target;
        logic                     jmp;
        logic [JIDX_W-1:0]        jmp_idx;
        logic                     br_take;
        logic signed [BOFF_W-1:0] br_off;
    } redirect_t;

    function automatic logic signed [WORD_W-1:0] sext_boff(input logic signed [BOFF_W-1:0] off);
        return {{(WORD_W - BOFF_W){off[BOFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jr > jmp > branch > sequential.
module fetch_next_pc
    import fetch_unit_pkg::*;
(
    input  logic [WORD_W-1:0] pc_plus1,
    input  redirect_t         req,
    output logic [WORD_W-1:0] next_pc
);

    logic signed [WORD_W-1:0] br_disp;
    logic [WORD_W-1:0]        br_target;
    logic [WORD_W-1:0]        jmp_target;

    assign br_disp    = sext_boff(req.br_off);
    // Branch arithmetic wraps modulo 2^32; the signed displacement is added bitwise.
    assign br_target  = pc_plus1 + WORD_W'(br_disp);
    assign jmp_target = {pc_plus1[WORD_W-1:JIDX_W], req.jmp_idx};

    always_comb begin
        next_pc = pc_plus1;
        if (req.jr) begin
            next_pc = req.jr_target;
        end else if (req.jmp) begin
            next_pc = jmp_target;
        end else if (req.br_take) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register, run/halt FSM and retired-fetch counter for the MIPS fetch stage.
// Optional `PC_BOUND_CHECK_EN halts with a sticky fault when next PC >= IM_DEPTH.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                IM_DEPTH = 32,
    parameter logic [WORD_W-1:0] RESET_PC = 32'd0
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     halt_req,
    input  logic                     br_take,
    input  logic signed [BOFF_W-1:0] br_off,
    input  logic                     jmp,
    input  logic [JIDX_W-1:0]        jmp_idx,
    input  logic                     jr,
    input  logic [WORD_W-1:0]        jr_target,
    output logic [WORD_W-1:0]        im_addr,
    input  logic [WORD_W-1:0]        im_data,
    output logic [WORD_W-1:0]        instr,
    output logic                     instr_valid,
    output logic [WORD_W-1:0]        pc,
    output logic [WORD_W-1:0]        pc_plus1,
    output logic                     halted,
    output logic                     fault,
    output logic [WORD_W-1:0]        fetch_cnt
);

    if (IM_DEPTH <= 0) begin : g_bad_depth
        $error("fetch_unit: IM_DEPTH must be positive");
    end

    state_t            state;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] cnt_q;
    logic              fault_q;
    logic [WORD_W-1:0] next_pc;
    logic              oob;
    redirect_t         req;

    assign req.jr        = jr;
    assign req.jr_target = jr_target;
    assign req.jmp       = jmp;
    assign req.jmp_idx   = jmp_idx;
    assign req.br_take   = br_take;
    assign req.br_off    = br_off;

    fetch_next_pc u_next_pc (
        .pc_plus1 (pc_plus1),
        .req      (req),
        .next_pc  (next_pc)
    );

`ifdef PC_BOUND_CHECK_EN
    assign oob = (next_pc >= WORD_W'(IM_DEPTH));
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_RUN: begin
                    // A halting or faulting fetch still retires, but the PC stays put.
                    if (!stall) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (halt_req) begin
                            state <= ST_HALTED;
                        end else if (oob) begin
                            fault_q <= 1'b1;
                            state   <= ST_HALTED;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                ST_HALTED: ;
                default: state <= ST_HALTED;
            endcase
        end
    end

    assign pc          = pc_q;
    assign im_addr     = pc_q;
    assign pc_plus1    = pc_q + 1'b1;
    assign instr       = im_data;
    assign instr_valid = (state == ST_RUN);
    assign halted      = (state == ST_HALTED);
    assign fault       = fault_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver pushes expected outputs from a
// behavioural model each cycle, and a separate monitor pops and compares.
module tb_fetch_unit;

    localparam int          IM_DEPTH = 32;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt_req;
    logic        br_take;
    logic [15:0] br_off;
    logic        jmp;
    logic [25:0] jmp_idx;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_cnt;

    fetch_unit #(.IM_DEPTH(IM_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .halt_req    (halt_req),
        .br_take     (br_take),
        .br_off      (br_off),
        .jmp         (jmp),
        .jmp_idx     (jmp_idx),
        .jr          (jr),
        .jr_target   (jr_target),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .halted      (halted),
        .fault       (fault),
        .fetch_cnt   (fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        vld;
        logic        hlt;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    // Reference model: "started" = left the post-reset idle cycle, "stopped" = halted.
    bit          m_started;
    bit          m_stopped;
    bit          m_fault;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic step(input bit rst, input bit st, input bit hr,
                        input bit bt, input logic [15:0] bo,
                        input bit j, input logic [25:0] ji,
                        input bit jrq, input logic [31:0] jt);
        exp_t        e;
        logic [31:0] tgt;
        int          off;
        @(negedge clk);
        rst_n     = !rst;
        stall     = st;
        halt_req  = hr;
        br_take   = bt;
        br_off    = bo;
        jmp       = j;
        jmp_idx   = ji;
        jr        = jrq;
        jr_target = jt;
        im_data   = $urandom;
        if (rst) begin
            m_started = 1'b0;
            m_stopped = 1'b0;
            m_fault   = 1'b0;
            m_pc      = RESET_PC;
            m_cnt     = 32'd0;
        end
        e.pc    = m_pc;
        e.instr = im_data;
        e.cnt   = m_cnt;
        e.vld   = m_started && !m_stopped;
        e.hlt   = m_stopped;
        e.flt   = m_fault;
        sb.push_back(e);
        if (!rst) begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (!m_stopped && !st) begin
                m_cnt = m_cnt + 32'd1;
                off   = $signed(bo);
                if (jrq)     tgt = jt;
                else if (j)  tgt = ((m_pc + 32'd1) & 32'hFC00_0000) | 32'(ji);
                else if (bt) tgt = m_pc + 32'd1 + 32'(off);
                else         tgt = m_pc + 32'd1;
                if (hr) begin
                    m_stopped = 1'b1;
                end else begin
`ifdef PC_BOUND_CHECK_EN
                    if (tgt >= IM_DEPTH) begin
                        m_fault   = 1'b1;
                        m_stopped = 1'b1;
                    end else begin
                        m_pc = tgt;
                    end
`else
                    m_pc = tgt;
`endif
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    task automatic goto_pc(input logic [31:0] t);
        step(0, 0, 0, 0, 16'h0, 0, 26'h0, 1, t);
    endtask

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        bit          r, st, hr, bt, j, jrq;
        logic [15:0] bo;
        logic [25:0] ji;
        logic [31:0] jt;
        rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; br_take = 1'b0; br_off = '0;
        jmp = 1'b0; jmp_idx = '0; jr = 1'b0; jr_target = '0; im_data = '0;

        do_reset(2);
        idle(6);                                            // idle cycle, then pc 0..4
        step(0, 0, 0, 1, 16'hFFFD, 0, 26'h0, 0, 32'h0);     // at pc 5: 6-3 = 3
        goto_pc(32'd5);
        step(0, 0, 0, 1, 16'h0004, 0, 26'h0, 0, 32'h0);     // 6+4 = 10
        goto_pc(32'd2);
        step(0, 0, 0, 1, 16'h0001, 1, 26'd7, 1, 32'd20);    // jr wins -> 20
        goto_pc(32'd4);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'h0, 1, 26'd9, 0, 32'h0);
        step(0, 0, 0, 0, 16'h0, 1, 26'd9, 0, 32'h0);        // -> 9
        goto_pc(32'd3);
        step(0, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);        // halt at pc 3
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h2, 1, 26'd5, 1, 32'd7);
        do_reset(1);
        idle(3);
        step(0, 1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);        // stall beats halt
        step(0, 1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        step(0, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        idle(2);
        do_reset(1);
        idle(1);
        goto_pc(32'd31);
        idle(3);                                            // sequential past the bound
        goto_pc(32'hFFFF_FFFF);
        idle(2);                                            // wrap to 0 when unchecked
        do_reset(1);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 3) == 0);
            hr  = ($urandom_range(0, 39) == 0);
            bt  = ($urandom_range(0, 3) == 0);
            bo  = 16'($urandom_range(0, 20)) - 16'd10;
            j   = ($urandom_range(0, 7) == 0);
            ji  = 26'($urandom_range(0, 40));
            jrq = ($urandom_range(0, 7) == 0);
            jt  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            step(r, st, hr, bt, bo, j, ji, jrq, jt);
        end
        done = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: samples mid-cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) begin
                if (done) break;
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard: got empty queue, expected an entry (t=%0t)", $time);
                continue;
            end
            e = sb.pop_front();
            chk("pc",          pc,                 e.pc);
            chk("im_addr",     im_addr,            e.pc);
            chk("pc_plus1",    pc_plus1,           e.pc + 32'd1);
            chk("instr",       instr,              e.instr);
            chk("instr_valid", 32'(instr_valid),   32'(e.vld));
            chk("halted",      32'(halted),        32'(e.hlt));
            chk("fault",       32'(fault),         32'(e.flt));
            chk("fetch_cnt",   fetch_cnt,          e.cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion, expected finish within budget");
        $fatal(1, "timeout");
    end

endmodule
